// File: rtl/mem_access_master.sv
// mem_access_master
//   Initiator side of the shared instruction/data memory port of the
//   multi-cycle CPU. It takes one load/store request at a time and drives a
//   word-addressed memory. Byte and halfword loads select a lane and extend
//   it. Sub-word stores are done as read-modify-write.
//
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN
//   When defined, a misaligned halfword or word request completes at once
//   with err=1 and never touches memory.
//   When undefined, err is tied low and the offending low address bits are
//   ignored.
//
// Parameters
//   WAIT_CYCLES  extra cycles MemRead is held before Mem_data is sampled (0..15)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   req         in   request strobe, sampled only in IDLE
//   we          in   1 = store, 0 = load
//   size        in   00 byte, 01 halfword, 10/11 word
//   sign_ext    in   load only: sign-extend (1) or zero-extend (0) sub-word data
//   addr        in   byte address
//   wdata       in   store data, sub-word value in the low bits
//   busy        out  request in progress (RD/WR states)
//   done        out  one-cycle completion pulse
//   rdata       out  last load result
//   err         out  misaligned request flag, valid with done
//   Address     out  word-aligned memory address
//   Write_data  out  memory write data
//   MemRead     out  memory read enable
//   MemWrite    out  memory write enable
//   Mem_data    in   memory read data (combinational from Address)
module mem_access_master #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Mem_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        misaligned;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the old word with the new data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic        half,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (half) r[{lane[1], 4'b0000} +: 16] = data[15:0];
    else      r[{lane, 3'b000} +: 8]      = data[7:0];
    return r;
  endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign misaligned = ((size == 2'b01) && addr[0]) ||
                      (size[1] && (addr[1:0] != 2'b00));
  assign err_d      = (state_q == S_IDLE && req) ? misaligned : err_q;
  assign err        = done & err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign rdata      = rdata_q;
  assign Address    = {addr_q[31:2], 2'b00};
  // Word stores (size 1x) write the captured data as-is; sub-word stores
  // write the read-back word with one lane replaced.
  assign Write_data = size_q[1] ? wdata_q
                                : store_merge(word_q, wdata_q, size_q[0], addr_q[1:0]);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr;
          wdata_d = wdata;
          if (misaligned) begin
            state_d = S_DONE;
          end else if (!we || !size[1]) begin
            // Loads and sub-word stores both need the current word first.
            state_d = S_RD;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            word_d  = Mem_data;
            state_d = S_WR;
          end else begin
            rdata_d = load_extract(Mem_data, size_q, addr_q[1:0], sext_q);
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR: begin
        busy     = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master: table of requests with expected
// results, a scoreboard queue popped on each done pulse, and hand-written
// reset-state and reset-during-read-modify-write sequences.
module tb_mem_access_master;

  localparam int W = 3;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    vec_t v;
    int   start;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, MemRead, MemWrite;
  logic [31:0] rdata, Address, Write_data, Mem_data;

  logic [31:0] mem [0:63];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_seen = 32'h0;
  logic [31:0] exp_last = 32'h0;
  logic [31:0] saved_word;
  sb_t         sb_q[$];
  sb_t         mon_e;
  vec_t        vecs[$];

  mem_access_master #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Mem_data   (Mem_data)
  );

  always #5 clk = ~clk;

  // Word-addressed memory model: combinational read, write on posedge.
  assign Mem_data = MemRead ? mem[Address[7:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (MemWrite) mem[Address[7:2]] <= Write_data;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic x,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee, input int lat,
                              input int nrd, input int nwr, input logic [31:0] ew);
    vec_t v;
    v = '{w, s, x, a, d, er, ee, lat, nrd, nwr, ew};
    return v;
  endfunction

  // Monitor: bus checks on every access cycle, scoreboard pop on done.
  always @(negedge clk) begin
    if (reset) begin
      if (MemRead || MemWrite) begin
        check("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
        if (sb_q.size() > 0) check("address", Address, {sb_q[0].v.addr[31:2], 2'b00});
      end
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        wr_cnt++;
        wr_seen = Write_data;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("latency", cyc - mon_e.start, mon_e.v.exp_lat);
          check("err", {31'b0, err}, {31'b0, mon_e.v.exp_err});
          if (!mon_e.v.we && !mon_e.v.exp_err) exp_last = mon_e.v.exp_rdata;
          check("rdata", rdata, exp_last);
          check("memread_cycles", rd_cnt, mon_e.v.exp_rd);
          check("memwrite_cycles", wr_cnt, mon_e.v.exp_wr);
          if (mon_e.v.exp_wr != 0) check("write_data", wr_seen, mon_e.v.exp_word);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || done) && t < 64) begin
      @(negedge clk);
      t++;
    end
    req      = 1'b1;
    we       = v.we;
    size     = v.size;
    sign_ext = v.sext;
    addr     = v.addr;
    wdata    = v.wdata;
    sb_q.push_back('{v, cyc});
    t = 0;
    @(negedge clk);
    // Keep req high with scrambled fields while busy: none of it may matter.
    while (!done && t < 64) begin
      we       = ~v.we;
      size     = ~v.size;
      sign_ext = ~v.sext;
      addr     = v.addr ^ 32'h24;
      wdata    = ~v.wdata;
      @(negedge clk);
      t++;
    end
    req = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout for addr 0x%08h: no done within 64 cycles", v.addr);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (v.exp_wr != 0) begin
      check("mem_word", mem[v.addr[7:2]], v.exp_word);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[0] <= 32'hDEADBEEF;
    mem[1] <= 32'h01234567;
    mem[2] <= 32'h80FF7F01;
    mem[4] <= 32'h8899AABB;
    mem[8] <= 32'h11223344;

    //       we    size   sx    addr   wdata         rdata         err   lat  rd   wr  word
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00008899, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF5A, 32'h0,        1'b0, 3+W, W+1, 1, 32'h5A223344));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h5A223344, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'hDEADBEEF, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h08, 32'h0,        32'h00000001, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'h0000007F, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0,        32'h000000FF, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h08, 32'h0,        32'h00007F01, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        32'hFFFF80FF, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'h000080FF, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'h0,        1'b0, 3+W, W+1, 1, 32'hBEEFAABB));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hBEEFAABB, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D, 32'h0,        1'b0, 2,   0,   1, 32'hCAFEF00D));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h00, 32'h13572468, 32'h0,        1'b0, 2,   0,   1, 32'h13572468));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        32'h13572468, 1'b0, 2+W, W+1, 0, 32'h0));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1, 1,   0,   0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1,   0,   0, 32'h0));
`else
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'hCAFEF00D, 1'b0, 2+W, W+1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        32'h0000BEEF, 1'b0, 2+W, W+1, 0, 32'h0));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy",       {31'b0, busy},     32'h0);
    check("reset_done",       {31'b0, done},     32'h0);
    check("reset_err",        {31'b0, err},      32'h0);
    check("reset_memread",    {31'b0, MemRead},  32'h0);
    check("reset_memwrite",   {31'b0, MemWrite}, 32'h0);
    check("reset_rdata",      rdata,             32'h0);
    check("reset_address",    Address,           32'h0);
    check("reset_write_data", Write_data,        32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulled low while a sub-word store is still reading.
    saved_word = mem[8];
    @(negedge clk);
    req      = 1'b1;
    we       = 1'b1;
    size     = 2'b00;
    sign_ext = 1'b0;
    addr     = 32'h21;
    wdata    = 32'h77;
    @(negedge clk);
    req = 1'b0;
    check("rmw_in_read", {31'b0, MemRead}, 32'h1);
    reset = 1'b0;
    #1;
    check("abort_busy",       {31'b0, busy},     32'h0);
    check("abort_memread",    {31'b0, MemRead},  32'h0);
    check("abort_memwrite",   {31'b0, MemWrite}, 32'h0);
    check("abort_done",       {31'b0, done},     32'h0);
    check("abort_rdata",      rdata,             32'h0);
    check("abort_address",    Address,           32'h0);
    check("abort_write_data", Write_data,        32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_cnt = 0;
    wr_cnt = 0;
    exp_last = 32'h0;
    repeat (W + 4) @(negedge clk);
    check("abort_busy_after",  {31'b0, busy}, 32'h0);
    check("abort_no_write",    wr_cnt,        32'h0);
    check("abort_mem_kept",    mem[8],        saved_word);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h5A223344, 1'b0, 2+W, W+1, 0, 32'h0));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
